bin2edge_encoder: RTL and testbench

- Converts binary values into race-logic temporal edges for the temporal operator fabric.
- One 0->1 edge per channel per gamma cycle, at a time slot equal to the binary value.
- Feeds temporal operators such as inequality, min/max and delay, which expect 0->1 edge inputs referenced to the grst gamma pulse.
- Accepts one vector of NUM_CH values per gamma cycle over a valid/ready handshake, with a single staging register.

---
 rtl/temporal_pkg.sv | 15 +
 rtl/bin2edge_encoder_edge_gen.sv | 45 ++++
 rtl/bin2edge_encoder.sv | 90 +++++++++
 tb/tb_bin2edge_encoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/temporal_pkg.sv
// Shared definitions for the race-logic temporal fabric: the NULL ("infinity")
// encoding, the default slot width and the saturating slot limit.
package temporal_pkg;

  localparam int unsigned TEMPORAL_W = 3;

  function automatic int unsigned null_val(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  typedef logic [TEMPORAL_W-1:0] slot_t;

  localparam int unsigned GAMMA_MAX = null_val(TEMPORAL_W);

endpackage

// File: rtl/bin2edge_encoder_edge_gen.sv
// One temporal channel: holds the active value for the current gamma cycle and
// a sticky edge flop that rises once the slot counter reaches that value.
module edge_gen
  import temporal_pkg::*;
#(
  parameter int unsigned W = TEMPORAL_W
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] slot_next,
  output logic         edge_out
);

  localparam logic [W-1:0] NULL_V = W'(null_val(W));

  logic [W-1:0] val_q, val_d;
  logic         edge_q, edge_d;

  // The saturated slot equals the NULL code, so NULL must be excluded from the match
  always_comb begin
    val_d  = val_q;
    edge_d = edge_q;
    if (load) begin
      val_d  = load_val;
      edge_d = (load_val == '0);
    end else if ((val_q != NULL_V) && (slot_next == val_q)) begin
      edge_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      val_q  <= NULL_V;
      edge_q <= 1'b0;
    end else begin
      val_q  <= val_d;
      edge_q <= edge_d;
    end
  end

  assign edge_out = edge_q;

endmodule

// File: rtl/bin2edge_encoder.sv
// Binary-to-race-logic encoder: one 0->1 edge per channel per gamma cycle at the
// slot given by the channel value, fed through a single-entry staging register.
module bin2edge_encoder
  import temporal_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned W      = TEMPORAL_W
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                grst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_CH*W-1:0] in_data,
  output logic [NUM_CH-1:0]   edge_out,
  output logic                underrun
);

  localparam logic [W-1:0] NULL_V   = W'(null_val(W));
  localparam logic [W-1:0] SLOT_SAT = W'((W == TEMPORAL_W) ? GAMMA_MAX : null_val(W));

  logic [W-1:0]        slot_q, slot_d;
  logic                stg_full_q, stg_full_d;
  logic [NUM_CH*W-1:0] stg_data_q, stg_data_d;
  logic                underrun_q, underrun_d;
  logic                load;
  logic [NUM_CH*W-1:0] load_vec;

  // Boundary priority: staged vector, then bypass of in_data, then all-NULL with underrun
  always_comb begin
    slot_d     = slot_q;
    stg_full_d = stg_full_q;
    stg_data_d = stg_data_q;
    underrun_d = 1'b0;
    load       = 1'b0;
    load_vec   = {NUM_CH{NULL_V}};
    if (slot_q != SLOT_SAT) begin
      slot_d = slot_q + 1'b1;
    end
    if (grst) begin
      load   = 1'b1;
      slot_d = '0;
      if (stg_full_q) begin
        load_vec   = stg_data_q;
        stg_full_d = 1'b0;
      end else if (in_valid) begin
        load_vec = in_data;
      end else begin
        underrun_d = 1'b1;
      end
    end else if (in_valid && !stg_full_q) begin
      stg_full_d = 1'b1;
      stg_data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      slot_q     <= '0;
      stg_full_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      stg_full_q <= stg_full_d;
      underrun_q <= underrun_d;
    end
  end

  // Staged payload is qualified by stg_full_q, so it needs no reset
  always_ff @(posedge clk) begin
    stg_data_q <= stg_data_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_gen #(
      .W(W)
    ) u_edge_gen (
      .clk      (clk),
      .rstb     (rstb),
      .load     (load),
      .load_val (load_vec[i*W +: W]),
      .slot_next(slot_d),
      .edge_out (edge_out[i])
    );
  end

  assign in_ready = ~stg_full_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_bin2edge_encoder.sv
// Directed bench for bin2edge_encoder (NUM_CH=4, W=3) with hand-computed edges.
module tb_bin2edge_encoder;

  logic        clk;
  logic        rstb;
  logic        grst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic [3:0]  edge_out;
  logic        underrun;

  int n_checks;
  int n_errors;

  bin2edge_encoder #(
    .NUM_CH(4),
    .W     (3)
  ) dut (
    .clk     (clk),
    .rstb    (rstb),
    .grst    (grst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .edge_out(edge_out),
    .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pack(input logic [2:0] c0, input logic [2:0] c1,
                                       input logic [2:0] c2, input logic [2:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  logic [3:0] basic_want [0:8];
  logic [3:0] short_want [0:4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    basic_want = '{4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0011,
                   4'b0111, 4'b0111, 4'b0111};
    short_want = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};

    rstb = 1'b0; grst = 1'b0; in_valid = 1'b0; in_data = '0;
    #2;
    check("rst_edge", 32'(edge_out), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h1);
    tick();
    tick();
    rstb = 1'b1;
    tick();

    // Basic encode {0,3,6,7}
    in_data = pack(3'd0, 3'd3, 3'd6, 3'd7); in_valid = 1'b1;
    tick();
    check("basic_staged_ready", 32'(in_ready), 32'h0);
    in_valid = 1'b0; grst = 1'b1;
    tick();
    grst = 1'b0;
    check("basic_ready_after_load", 32'(in_ready), 32'h1);
    for (int s = 0; s <= 8; s++) begin
      if (s > 0) tick();
      check($sformatf("basic_slot%0d", s), 32'(edge_out), 32'(basic_want[s]));
    end

    // Underrun: boundary with nothing available
    grst = 1'b1;
    tick();
    grst = 1'b0;
    check("underrun_pulse", 32'(underrun), 32'h1);
    check("underrun_clear_edges", 32'(edge_out), 32'h0);
    for (int s = 1; s <= 8; s++) begin
      tick();
      check($sformatf("underrun_slot%0d_pulse", s), 32'(underrun), 32'h0);
      check($sformatf("underrun_slot%0d_edge", s), 32'(edge_out), 32'h0);
    end

    // Staged {1,1,1,1}
    in_data = pack(3'd1, 3'd1, 3'd1, 3'd1); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("staged_ready_low", 32'(in_ready), 32'h0);
    tick();
    check("staged_ready_hold", 32'(in_ready), 32'h0);
    grst = 1'b1;
    tick();
    grst = 1'b0;
    check("staged_ready_back", 32'(in_ready), 32'h1);
    check("staged_slot0", 32'(edge_out), 32'h0);
    tick();
    check("staged_slot1", 32'(edge_out), 32'hF);

    // Bypass {2,2,2,2} on the boundary cycle
    in_data = pack(3'd2, 3'd2, 3'd2, 3'd2); in_valid = 1'b1; grst = 1'b1;
    check("bypass_ready_pre", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0; grst = 1'b0;
    check("bypass_ready_post", 32'(in_ready), 32'h1);
    check("bypass_no_underrun", 32'(underrun), 32'h0);
    check("bypass_slot0", 32'(edge_out), 32'h0);
    tick();
    check("bypass_slot1", 32'(edge_out), 32'h0);
    check("bypass_ready_slot1", 32'(in_ready), 32'h1);
    tick();
    check("bypass_slot2", 32'(edge_out), 32'hF);

    // Short gamma: value 5 with grst every 4 cycles, then {1,2,3,4}
    in_data = pack(3'd5, 3'd5, 3'd5, 3'd5); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; grst = 1'b1;
    tick();
    grst = 1'b0;
    check("short_slot0", 32'(edge_out), 32'h0);
    in_data = pack(3'd1, 3'd2, 3'd3, 3'd4); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("short_slot1", 32'(edge_out), 32'h0);
    tick();
    check("short_slot2", 32'(edge_out), 32'h0);
    tick();
    check("short_slot3", 32'(edge_out), 32'h0);
    grst = 1'b1;
    tick();
    grst = 1'b0;
    check("short_next_no_underrun", 32'(underrun), 32'h0);
    for (int s = 0; s <= 4; s++) begin
      if (s > 0) tick();
      check($sformatf("short_next_slot%0d", s), 32'(edge_out), 32'(short_want[s]));
    end

    // Async reset mid-gamma with {0,4,4,4} active and a vector staged
    in_data = pack(3'd0, 3'd4, 3'd4, 3'd4); in_valid = 1'b1; grst = 1'b1;
    tick();
    grst = 1'b0; in_valid = 1'b0;
    check("arst_slot0", 32'(edge_out), 32'h1);
    in_data = pack(3'd1, 3'd1, 3'd1, 3'd1); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("arst_slot1", 32'(edge_out), 32'h1);
    tick();
    check("arst_slot2", 32'(edge_out), 32'h1);
    check("arst_staged", 32'(in_ready), 32'h0);
    #2;
    rstb = 1'b0;
    #1;
    check("arst_edge_now", 32'(edge_out), 32'h0);
    check("arst_ready_now", 32'(in_ready), 32'h1);
    tick();
    tick();
    rstb = 1'b1;
    for (int s = 0; s < 6; s++) begin
      tick();
      check($sformatf("arst_quiet%0d", s), 32'(edge_out), 32'h0);
    end
    grst = 1'b1;
    tick();
    grst = 1'b0;
    check("arst_staging_cleared", 32'(underrun), 32'h1);

    // Back-to-back grst: staged A, bypass B, then underrun
    tick();
    in_data = pack(3'd0, 3'd0, 3'd7, 3'd7); in_valid = 1'b1;
    tick();
    in_data = pack(3'd7, 3'd7, 3'd0, 3'd0); in_valid = 1'b1; grst = 1'b1;
    tick();
    check("b2b_first_staged", 32'(edge_out), 32'h3);
    check("b2b_first_ready", 32'(in_ready), 32'h1);
    check("b2b_first_underrun", 32'(underrun), 32'h0);
    tick();
    in_valid = 1'b0;
    check("b2b_second_bypass", 32'(edge_out), 32'hC);
    check("b2b_second_ready", 32'(in_ready), 32'h1);
    check("b2b_second_underrun", 32'(underrun), 32'h0);
    tick();
    grst = 1'b0;
    check("b2b_third_edge", 32'(edge_out), 32'h0);
    check("b2b_third_underrun", 32'(underrun), 32'h1);
    tick();
    check("b2b_underrun_one_cycle", 32'(underrun), 32'h0);
    check("b2b_null_hold", 32'(edge_out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
